spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master controller: frames {op, tx_byte} onto MOSI after a start and select bit,
// and for read-data commands waits RD_WAIT cycles then shifts 8 MISO bits into rd_byte.
module spi_master_ctrl #(
   parameter int RD_WAIT = 2,
   parameter int GAP     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [7:0] tx_byte,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_byte,
   output logic       rd_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SEL   = 3'd2,
      SHIFT = 3'd3,
      WAIT  = 3'd4,
      RECV  = 3'd5,
      STOP  = 3'd6
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
   localparam logic [3:0] SHIFT_LAST = 4'd9;
   localparam logic [3:0] RECV_LAST  = 4'd7;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] frame_q, frame_d;
   logic [6:0] rx_sh_q;
   logic       accept;
   logic       is_read;

   logic       ss_n_d, mosi_d, busy_d, done_d, rd_valid_d;
   logic [3:0] bit_sel;

   // busy is low in IDLE and in the final STOP cycle, so that cycle is the acceptance slot
   assign accept  = start && !busy;
   assign is_read = (frame_q[9:8] == 2'b11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         frame_q <= '0;
         rx_sh_q <= '0;
         rd_byte <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         if (state_q == RECV) begin
            rx_sh_q <= {rx_sh_q[5:0], MISO};
            if (cnt_q == RECV_LAST) begin
               rd_byte <= {rx_sh_q, MISO};
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               frame_d = {op, tx_byte};
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            state_d = SEL;
         end
         SEL: begin
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               cnt_d   = '0;
               state_d = is_read ? WAIT : STOP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = RECV;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RECV: begin
            if (cnt_q == RECV_LAST) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         STOP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (accept) begin
                  frame_d = {op, tx_byte};
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q
   always_comb begin
      ss_n_d     = 1'b1;
      mosi_d     = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      bit_sel    = SHIFT_LAST - cnt_d;
      case (state_d)
         IDLE: begin
            busy_d = 1'b0;
         end
         START: begin
            ss_n_d = 1'b0;
         end
         SEL: begin
            ss_n_d = 1'b0;
            mosi_d = frame_d[9];
         end
         SHIFT: begin
            ss_n_d = 1'b0;
            mosi_d = frame_d[bit_sel];
         end
         WAIT, RECV: begin
            ss_n_d = 1'b0;
         end
         STOP: begin
            busy_d = (cnt_d != GAP_LAST);
            if (state_q != STOP) begin
               done_d     = 1'b1;
               rd_valid_d = is_read;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         SS_n     <= ss_n_d;
         MOSI     <= mosi_d;
         busy     <= busy_d;
         done     <= done_d;
         rd_valid <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: behavioural SPI slave with RAM, a frame monitor,
// a directed vector table and hand-written sequences for gap, busy-start and reset cases.
module tb_spi_master_ctrl;

   localparam int RD_WAIT = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] op;
   logic [7:0] tx_byte;
   logic       busy, done, rd_valid, SS_n, MOSI;
   logic [7:0] rd_byte;
   logic       MISO;

   spi_master_ctrl #(.RD_WAIT(RD_WAIT), .GAP(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .tx_byte(tx_byte),
      .busy(busy), .done(done), .rd_byte(rd_byte), .rd_valid(rd_valid),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   // Slave: samples MOSI on rising edges, decodes the 10-bit frame, serves reads from RAM
   logic [31:0] s_bits;
   int          s_k;
   logic [7:0]  s_addr, s_rdata;
   logic [7:0]  ram [256];
   logic [9:0]  s_frame;
   int          s_idx;
   logic        ovr_en = 1'b0;
   logic [7:0]  ovr_val = 8'h00;

   assign s_frame = {s_bits[8:0], MOSI};
   assign s_idx   = s_k + 1 - (12 + RD_WAIT);

   always @(posedge clk) begin
      if (!SS_n) begin
         s_k    <= s_k + 1;
         s_bits <= {s_bits[30:0], MOSI};
         if (s_k == 11) begin
            case (s_frame[9:8])
               2'b00, 2'b10: s_addr <= s_frame[7:0];
               2'b01:        ram[s_addr] <= s_frame[7:0];
               default:      s_rdata <= ovr_en ? ovr_val : ram[s_addr];
            endcase
         end
         MISO <= (s_idx >= 0 && s_idx < 8) ? s_rdata[7 - s_idx] : 1'b0;
      end else begin
         s_k    <= 0;
         s_bits <= '0;
         MISO   <= 1'b0;
      end
   end

   // Frame monitor on the falling edge
   logic [31:0] cur_bits = '0, last_bits = '0;
   int cur_len = 0, last_len = 0, frames = 0, hi_run = 0, last_gap = 0;
   int done_cnt = 0, rv_cnt = 0, mosi_hi_err = 0, place_err = 0;
   logic ss_prev = 1'b1;

   always @(negedge clk) begin
      if (SS_n === 1'b0) begin
         cur_bits <= {cur_bits[30:0], MOSI};
         cur_len  <= cur_len + 1;
         if (ss_prev) last_gap <= hi_run;
      end else begin
         if (!ss_prev) begin
            last_bits <= cur_bits;
            last_len  <= cur_len;
            frames    <= frames + 1;
            cur_bits  <= '0;
            cur_len   <= 0;
         end
         hi_run <= ss_prev ? hi_run + 1 : 1;
         if (MOSI !== 1'b0) mosi_hi_err <= mosi_hi_err + 1;
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (rd_valid === 1'b1) rv_cnt <= rv_cnt + 1;
      if ((done === 1'b1) && !(SS_n === 1'b1 && !ss_prev)) place_err <= place_err + 1;
      if ((rd_valid === 1'b1) && (done !== 1'b1)) place_err <= place_err + 1;
      ss_prev <= SS_n;
   end

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [7:0] b);
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 100) begin
         n_cmp++; n_fail++;
         $display("FAIL issue_wait: busy stuck at %b, want 0", busy);
      end
      @(negedge clk);
      start = 1'b1; op = o; tx_byte = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (frames < target && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (frames < target) begin
         n_cmp++; n_fail++;
         $display("FAIL frame_timeout: frames %0d, want %0d", frames, target);
      end
   endtask

   task automatic txn(input logic [1:0] o, input logic [7:0] b);
      int f0 = frames;
      issue(o, b);
      wait_frames(f0 + 1);
   endtask

   function automatic logic [11:0] head12();
      int sh = (last_len >= 12) ? last_len - 12 : 0;
      return 12'((last_bits >> sh) & 32'hFFF);
   endfunction

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  b;
      int          len;
      logic [11:0] mosi;
      logic [7:0]  rd;
   } vec_t;

   vec_t tbl [10];
   logic [7:0] ref_mem [256];
   logic [7:0] r_addr [6];

   initial begin
      int d0, r0, f0;
      tbl[0] = '{2'b00, 8'hA5, 12, 12'h0A5, 8'h00};
      tbl[1] = '{2'b01, 8'h3C, 12, 12'h13C, 8'h00};
      tbl[2] = '{2'b10, 8'hA5, 12, 12'h6A5, 8'h00};
      tbl[3] = '{2'b11, 8'h00, 22, 12'h700, 8'h3C};
      tbl[4] = '{2'b00, 8'h5A, 12, 12'h05A, 8'h3C};
      tbl[5] = '{2'b01, 8'hC3, 12, 12'h1C3, 8'h3C};
      tbl[6] = '{2'b10, 8'h5A, 12, 12'h65A, 8'h3C};
      tbl[7] = '{2'b11, 8'hFF, 22, 12'h7FF, 8'hC3};
      tbl[8] = '{2'b10, 8'hA5, 12, 12'h6A5, 8'hC3};
      tbl[9] = '{2'b11, 8'h00, 22, 12'h700, 8'h3C};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; tx_byte = 8'h00;
      #23;
      chk("rst_ss_n", SS_n, 1); chk("rst_mosi", MOSI, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_byte", rd_byte, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         d0 = done_cnt; r0 = rv_cnt;
         txn(tbl[i].op, tbl[i].b);
         chk($sformatf("vec%0d_len", i), last_len, tbl[i].len);
         chk($sformatf("vec%0d_mosi", i), head12(), tbl[i].mosi);
         if (tbl[i].op == 2'b11)
            chk($sformatf("vec%0d_tail", i), last_bits & 32'h3FF, 0);
         chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
         chk($sformatf("vec%0d_rdv", i), rv_cnt - r0, (tbl[i].op == 2'b11) ? 1 : 0);
         chk($sformatf("vec%0d_rd_byte", i), rd_byte, tbl[i].rd);
      end
      chk("ram_a5", ram[8'hA5], 8'h3C);

      // MISO override: slave returns 8'h96 regardless of RAM
      ovr_val = 8'h96; ovr_en = 1'b1;
      r0 = rv_cnt;
      txn(2'b11, 8'h00);
      ovr_en = 1'b0;
      chk("ovr_len", last_len, 22);
      chk("ovr_rd_byte", rd_byte, 8'h96);
      chk("ovr_rdv", rv_cnt - r0, 1);

      // Back-to-back with start held high
      d0 = done_cnt; f0 = frames;
      issue(2'b00, 8'h11);
      start = 1'b1; op = 2'b01; tx_byte = 8'h22;
      wait_frames(f0 + 1);
      for (int n = 0; n < 50 && busy !== 1'b1; n++) begin
         @(negedge clk); #1;
      end
      start = 1'b0;
      wait_frames(f0 + 2);
      chk("b2b_gap", last_gap, 1);
      chk("b2b_len", last_len, 12);
      chk("b2b_mosi", head12(), 12'h122);
      chk("b2b_done", done_cnt - d0, 2);
      chk("b2b_ram", ram[8'h11], 8'h22);
      repeat (5) @(negedge clk);
      chk("b2b_frames", frames - f0, 2);

      // Start pulsed while busy must be dropped
      d0 = done_cnt; f0 = frames;
      issue(2'b10, 8'h44);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'b00; tx_byte = 8'h77;
      @(negedge clk);
      start = 1'b0;
      wait_frames(f0 + 1);
      repeat (30) @(negedge clk);
      chk("ign_frames", frames - f0, 1);
      chk("ign_done", done_cnt - d0, 1);
      chk("ign_addr", s_addr, 8'h44);

      // Reset in the middle of SHIFT
      issue(2'b00, 8'h5A);
      repeat (5) @(negedge clk);
      d0 = done_cnt; r0 = rv_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ss_n", SS_n, 1); chk("mid_rst_mosi", MOSI, 0);
      chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
      chk("mid_rst_rd_byte", rd_byte, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_no_rdv", rv_cnt - r0, 0);
      txn(2'b00, 8'h5A);
      chk("post_rst_len", last_len, 12);
      chk("post_rst_mosi", head12(), 12'h05A);

      // Random writes then read-back against a reference memory
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a, d;
         a = 8'($urandom); d = 8'($urandom);
         r_addr[i] = a; ref_mem[a] = d;
         txn(2'b00, a); chk($sformatf("rnd%0d_wa_len", i), last_len, 12);
         txn(2'b01, d); chk($sformatf("rnd%0d_wd_len", i), last_len, 12);
      end
      for (int i = 0; i < 6; i++) begin
         txn(2'b10, r_addr[i]);
         txn(2'b11, 8'($urandom));
         chk($sformatf("rnd%0d_rd_len", i), last_len, 22);
         chk($sformatf("rnd%0d_rd_byte", i), rd_byte, ref_mem[r_addr[i]]);
      end

      chk("mosi_while_ss_high", mosi_hi_err, 0);
      chk("pulse_placement", place_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: time %0t, want completion", $time);
      $fatal(1, "timeout");
   end

endmodule
